tcam_host_ctrl: RTL and testbench

Command-side controller that owns the TCAM array's write and search ports. It accepts valid/ready commands (write entry, search key, fill all entries) and sequences the TCAM enables with the correct timing. It captures each search result one cycle after the search strobe and returns it on a valid/ready response channel. It also keeps saturating search and hit statistics.

---
 rtl/tcam_host_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tcam_host_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_host_ctrl.sv
// rtl/tcam_host_ctrl.sv - command/response controller for a TCAM write/search port
//
// Purpose: accepts write/search/fill commands on a valid/ready channel, sequences
// the TCAM write and search strobes, captures each search result one cycle after
// the strobe and returns it on a valid/ready response channel. It also keeps
// saturating counts of searches and hits.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only while idle)
//   cmd_op/addr/data/mask    00 write, 01 search, 10 fill, 11 reserved
//   rsp_valid/rsp_ready      search result handshake
//   rsp_hit/rsp_data         result: hit flag and matched entry data (0 on miss)
//   err_cmd                  one-cycle pulse on a reserved opcode
//   tcam_wr_*                TCAM write port (strobe, addr, data, mask)
//   tcam_search_en/key       TCAM search port
//   tcam_match_found/data    TCAM result, valid the cycle after the search strobe
//   stat_searches/stat_hits  saturating statistics
module tcam_host_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cmd_mask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic [WIDTH-1:0] rsp_data,
  output logic             err_cmd,
  output logic             tcam_wr_en,
  output logic [AW-1:0]    tcam_wr_addr,
  output logic [WIDTH-1:0] tcam_wr_data,
  output logic [WIDTH-1:0] tcam_wr_mask,
  output logic             tcam_search_en,
  output logic [WIDTH-1:0] tcam_search_key,
  input  logic             tcam_match_found,
  input  logic [WIDTH-1:0] tcam_match_data,
  output logic [CNT_W-1:0] stat_searches,
  output logic [CNT_W-1:0] stat_hits
);

  typedef enum logic [2:0] {IDLE, WR, SRCH, CAPT, RSP, FILL} state_t;

  localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state, w_state;
  logic             r_wr_en, w_wr_en;
  logic [AW-1:0]    r_wr_addr, w_wr_addr;
  logic [WIDTH-1:0] r_wr_data, w_wr_data;
  logic [WIDTH-1:0] r_wr_mask, w_wr_mask;
  logic             r_srch_en, w_srch_en;
  logic [WIDTH-1:0] r_key, w_key;
  logic             r_rsp_valid, w_rsp_valid;
  logic             r_rsp_hit, w_rsp_hit;
  logic [WIDTH-1:0] r_rsp_data, w_rsp_data;
  logic             r_err, w_err;
  logic [CNT_W-1:0] r_searches, w_searches;
  logic [CNT_W-1:0] r_hits, w_hits;

  // Next-state and next-output logic. Strobes are computed one cycle ahead so
  // that the registered strobe is high exactly while the FSM sits in WR/SRCH/FILL.
  always_comb begin
    w_state     = r_state;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_wr_addr;
    w_wr_data   = r_wr_data;
    w_wr_mask   = r_wr_mask;
    w_srch_en   = 1'b0;
    w_key       = r_key;
    w_rsp_valid = r_rsp_valid;
    w_rsp_hit   = r_rsp_hit;
    w_rsp_data  = r_rsp_data;
    w_err       = 1'b0;
    w_searches  = r_searches;
    w_hits      = r_hits;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b00: begin
              w_state   = WR;
              w_wr_en   = 1'b1;
              w_wr_addr = cmd_addr;
              w_wr_data = cmd_data;
              w_wr_mask = cmd_mask;
            end
            2'b01: begin
              w_state   = SRCH;
              w_srch_en = 1'b1;
              w_key     = cmd_data;
            end
            2'b10: begin
              // The write address register doubles as the fill counter.
              w_state   = FILL;
              w_wr_en   = 1'b1;
              w_wr_addr = '0;
              w_wr_data = cmd_data;
              w_wr_mask = cmd_mask;
            end
            default: w_err = 1'b1;
          endcase
        end
      end
      WR:   w_state = IDLE;
      SRCH: w_state = CAPT;
      CAPT: begin
        w_state     = RSP;
        w_rsp_valid = 1'b1;
        w_rsp_hit   = tcam_match_found;
        w_rsp_data  = tcam_match_found ? tcam_match_data : '0;
        if (r_searches != CNT_MAX) w_searches = r_searches + CNT_W'(1);
        if (tcam_match_found && r_hits != CNT_MAX) w_hits = r_hits + CNT_W'(1);
      end
      RSP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = IDLE;
        end
      end
      FILL: begin
        if (r_wr_addr == LAST_ADDR) begin
          w_state = IDLE;
        end else begin
          w_wr_en   = 1'b1;
          w_wr_addr = r_wr_addr + AW'(1);
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_mask   <= '0;
      r_srch_en   <= 1'b0;
      r_key       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
      r_searches  <= '0;
      r_hits      <= '0;
    end else begin
      r_state     <= w_state;
      r_wr_en     <= w_wr_en;
      r_wr_addr   <= w_wr_addr;
      r_wr_data   <= w_wr_data;
      r_wr_mask   <= w_wr_mask;
      r_srch_en   <= w_srch_en;
      r_key       <= w_key;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_hit   <= w_rsp_hit;
      r_rsp_data  <= w_rsp_data;
      r_err       <= w_err;
      r_searches  <= w_searches;
      r_hits      <= w_hits;
    end
  end

  assign cmd_ready       = (r_state == IDLE);
  assign rsp_valid       = r_rsp_valid;
  assign rsp_hit         = r_rsp_hit;
  assign rsp_data        = r_rsp_data;
  assign err_cmd         = r_err;
  assign tcam_wr_en      = r_wr_en;
  assign tcam_wr_addr    = r_wr_addr;
  assign tcam_wr_data    = r_wr_data;
  assign tcam_wr_mask    = r_wr_mask;
  assign tcam_search_en  = r_srch_en;
  assign tcam_search_key = r_key;
  assign stat_searches   = r_searches;
  assign stat_hits       = r_hits;

endmodule

// File: tb/tb_tcam_host_ctrl.sv
// tb/tb_tcam_host_ctrl.sv - self-checking bench for tcam_host_ctrl with a TCAM stand-in
module tb_tcam_host_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int AW    = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [AW-1:0]    cmd_addr;
  logic [WIDTH-1:0] cmd_data, cmd_mask;
  logic             rsp_valid, rsp_ready, rsp_hit;
  logic [WIDTH-1:0] rsp_data;
  logic             err_cmd;
  logic             tcam_wr_en;
  logic [AW-1:0]    tcam_wr_addr;
  logic [WIDTH-1:0] tcam_wr_data, tcam_wr_mask;
  logic             tcam_search_en;
  logic [WIDTH-1:0] tcam_search_key;
  logic             tcam_match_found;
  logic [WIDTH-1:0] tcam_match_data;
  logic [CNT_W-1:0] stat_searches, stat_hits;

  tcam_host_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_data(rsp_data),
    .err_cmd(err_cmd),
    .tcam_wr_en(tcam_wr_en), .tcam_wr_addr(tcam_wr_addr),
    .tcam_wr_data(tcam_wr_data), .tcam_wr_mask(tcam_wr_mask),
    .tcam_search_en(tcam_search_en), .tcam_search_key(tcam_search_key),
    .tcam_match_found(tcam_match_found), .tcam_match_data(tcam_match_data),
    .stat_searches(stat_searches), .stat_hits(stat_hits)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // TCAM stand-in: writes land at the edge; search results appear the cycle after the strobe.
  logic [WIDTH-1:0] st_d [DEPTH];
  logic [WIDTH-1:0] st_m [DEPTH];
  bit               st_v [DEPTH];

  function automatic logic [WIDTH:0] stub_lookup(input logic [WIDTH-1:0] key);
    logic [WIDTH:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++)
      if (st_v[i] && (((key ^ st_d[i]) & st_m[i]) == '0)) r = {1'b1, st_d[i]};
    return r;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) st_v[i] = 1'b0;
    tcam_match_found = 1'b0;
    tcam_match_data  = '0;
  end

  always @(posedge clk) begin
    if (tcam_search_en) {tcam_match_found, tcam_match_data} <= stub_lookup(tcam_search_key);
    if (tcam_wr_en) begin
      st_d[tcam_wr_addr] <= tcam_wr_data;
      st_m[tcam_wr_addr] <= tcam_wr_mask;
      st_v[tcam_wr_addr] <= 1'b1;
    end
  end

  // Reference model at command level.
  logic [WIDTH-1:0] ref_d [DEPTH];
  logic [WIDTH-1:0] ref_m [DEPTH];
  bit               ref_v [DEPTH];
  int exp_srch = 0, exp_hits = 0, exp_wr_cycles = 0;
  int wr_cycles = 0, excl_viol = 0;

  always @(negedge clk) begin
    if (tcam_wr_en) wr_cycles++;
    if (tcam_wr_en && tcam_search_en) excl_viol++;
  end

  function automatic void predict(input logic [WIDTH-1:0] key, output bit hit,
                                  output logic [WIDTH-1:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ref_v[i] && (((key ^ ref_d[i]) & ref_m[i]) == '0)) begin
        hit = 1'b1;
        d   = ref_d[i];
      end
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    if (!ok) begin
      chk("cmd_ready_timeout", 0, 1);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = AW'($urandom);
    cmd_data = WIDTH'($urandom); cmd_mask = WIDTH'($urandom);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                          input logic [WIDTH-1:0] m);
    bit ok;
    do_cmd(2'b00, a, d, m, ok);
    if (!ok) return;
    ref_d[a] = d; ref_m[a] = m; ref_v[a] = 1'b1;
    exp_wr_cycles++;
    @(negedge clk);
    chk("wr_en", tcam_wr_en, 1);
    chk("wr_addr", tcam_wr_addr, a);
    chk("wr_data", tcam_wr_data, d);
    chk("wr_mask", tcam_wr_mask, m);
    chk("wr_busy", cmd_ready, 0);
    @(negedge clk);
    chk("wr_en_off", tcam_wr_en, 0);
    chk("wr_ready_back", cmd_ready, 1);
  endtask

  task automatic do_search(input logic [WIDTH-1:0] key, input int hold);
    bit ok, eh;
    logic [WIDTH-1:0] ed;
    predict(key, eh, ed);
    do_cmd(2'b01, AW'($urandom), key, WIDTH'($urandom), ok);
    if (!ok) return;
    @(negedge clk);
    chk("srch_en", tcam_search_en, 1);
    chk("srch_key", tcam_search_key, key);
    chk("srch_no_wr", tcam_wr_en, 0);
    @(negedge clk);
    chk("srch_en_off", tcam_search_en, 0);
    chk("rsp_early", rsp_valid, 0);
    @(negedge clk);
    exp_srch = sat_inc(exp_srch);
    if (eh) exp_hits = sat_inc(exp_hits);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_hit", rsp_hit, eh);
    chk("rsp_data", rsp_data, ed);
    chk("stat_searches", stat_searches, exp_srch);
    chk("stat_hits", stat_hits, exp_hits);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_hit", rsp_hit, eh);
      chk("hold_data", rsp_data, ed);
      chk("hold_busy", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("rsp_ready_back", cmd_ready, 1);
  endtask

  task automatic do_fill(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
    bit ok;
    do_cmd(2'b10, AW'($urandom), d, m, ok);
    if (!ok) return;
    for (int i = 0; i < DEPTH; i++) begin
      ref_d[i] = d; ref_m[i] = m; ref_v[i] = 1'b1;
    end
    exp_wr_cycles += DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("fill_en", tcam_wr_en, 1);
      chk("fill_addr", tcam_wr_addr, i);
      chk("fill_data", tcam_wr_data, d);
      chk("fill_mask", tcam_wr_mask, m);
    end
    @(negedge clk);
    chk("fill_en_off", tcam_wr_en, 0);
    chk("fill_ready_back", cmd_ready, 1);
  endtask

  task automatic do_err();
    bit ok;
    do_cmd(2'b11, AW'($urandom), WIDTH'($urandom), WIDTH'($urandom), ok);
    if (!ok) return;
    @(negedge clk);
    chk("err_pulse", err_cmd, 1);
    chk("err_no_wr", tcam_wr_en, 0);
    chk("err_no_srch", tcam_search_en, 0);
    chk("err_ready", cmd_ready, 1);
    @(negedge clk);
    chk("err_off", err_cmd, 0);
  endtask

  initial begin
    bit ok;
    logic [AW-1:0] a;
    logic [WIDTH-1:0] k;
    for (int i = 0; i < DEPTH; i++) ref_v[i] = 1'b0;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", {rsp_hit, rsp_data}, 0);
    chk("rst_strobes", {tcam_wr_en, tcam_search_en, err_cmd}, 0);
    chk("rst_stats", {stat_searches, stat_hits}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);

    do_write(2'd0, 8'hA5, 8'hF0);
    do_search(8'hAF, 0);
    do_search(8'h15, 0);
    do_search(8'hA0, 5);
    do_fill(8'h3C, 8'hFF);
    do_search(8'h3C, 0);
    do_search(8'h3D, 0);
    do_err();

    // Reset while the search result is being captured.
    do_cmd(2'b01, '0, 8'h3C, '0, ok);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_strobes", {tcam_wr_en, tcam_search_en}, 0);
    chk("mid_rst_stats", {stat_searches, stat_hits}, 0);
    exp_srch = 0; exp_hits = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_no_rsp", rsp_valid, 0);
    chk("post_rst_ready", cmd_ready, 1);
    do_write(2'd0, 8'hA5, 8'hF0);
    do_search(8'hAF, 0);

    // Randomized traffic; enough searches to drive the narrow counters to saturation.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 2) == 0)
        do_write(AW'($urandom), WIDTH'($urandom), WIDTH'($urandom) | 8'h81);
      if ($urandom_range(0, 7) == 0) do_err();
      if ($urandom_range(0, 1) == 0) begin
        a = AW'($urandom);
        k = ref_v[a] ? (ref_d[a] ^ (WIDTH'($urandom) & ~ref_m[a])) : WIDTH'($urandom);
      end else begin
        k = WIDTH'($urandom);
      end
      do_search(k, $urandom_range(0, 3));
    end
    chk("stat_saturated", stat_searches, CMAX);
    chk("wr_cycle_count", wr_cycles, exp_wr_cycles);
    chk("strobe_exclusive", excl_viol, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
